seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// =============================================================================
// seg7_scan_decoder : stability-qualified decoder for a muxed active-low 7-seg bus
// Optional macro SEG7DEC_DP_EN adds decimal-point capture (dp / dp_out). Rev 1.0
// =============================================================================
module seg7_scan_decoder #(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        seg,
   input  logic [NDIG-1:0]   an,
`ifdef SEG7DEC_DP_EN
   input  logic              dp,
   output logic [NDIG-1:0]   dp_out,
`endif
   input  logic              clr_err,
   output logic [4*NDIG-1:0] value,
   output logic [NDIG-1:0]   valid,
   output logic              upd,
   output logic [2:0]        upd_idx,
   output logic              err
);

   localparam logic [1:0] c_st_wait = 2'd0;
   localparam logic [1:0] c_st_qual = 2'd1;
   localparam logic [1:0] c_st_hold = 2'd2;
   localparam logic [7:0] c_stable  = 8'(STABLE_CYC);
   localparam logic [6:0] c_blank   = 7'h7F;
`ifdef SEG7DEC_DP_EN
   localparam int c_pw = 8 + NDIG;
`else
   localparam int c_pw = 7 + NDIG;
`endif

   logic [6:0]        seg_q, seg_d;
   logic [NDIG-1:0]   an_q, an_d;
   logic [c_pw-1:0]   prev_q, prev_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        state_q, state_d;
   logic [4*NDIG-1:0] value_q, value_d;
   logic [NDIG-1:0]   valid_q, valid_d;
   logic              upd_q, upd_d;
   logic [2:0]        upd_idx_q, upd_idx_d;
   logic              err_q, err_d;

   logic [c_pw-1:0]   w_pair;
   logic [NDIG-1:0]   w_an_low;
   logic              w_onehot;
   logic              w_changed;
   logic              w_hit;
   logic              w_capture;
   logic [2:0]        w_idx;
   logic [3:0]        w_nib;
   logic              w_legal;
   logic              w_blank;

`ifdef SEG7DEC_DP_EN
   logic              dp_q, dp_d;
   logic [NDIG-1:0]   dp_out_q, dp_out_d;
   assign w_pair = {dp_q, an_q, seg_q};
`else
   assign w_pair = {an_q, seg_q};
`endif

   // Input stage: the current sample and the one before it form the compared pair.
   always_comb begin
      seg_d  = seg;
      an_d   = an;
      prev_d = w_pair;
   end

   assign w_an_low  = ~an_q;
   assign w_onehot  = (w_an_low != '0) && ((w_an_low & (w_an_low - 1'b1)) == '0);
   assign w_changed = (w_pair != prev_q);

   always_comb begin
      cnt_d = cnt_q;
      if (!w_onehot) begin
         cnt_d = 8'd0;
      end else if (w_changed) begin
         cnt_d = 8'd1;
      end else if (cnt_q < c_stable) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign w_hit = (cnt_d == c_stable);

   // FSM next state: a hit on the very first sample (STABLE_CYC=1) goes straight to HOLD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_wait: begin
            if (w_onehot) begin
               state_d = w_hit ? c_st_hold : c_st_qual;
            end
         end
         c_st_qual: begin
            if (!w_onehot) begin
               state_d = c_st_wait;
            end else if (w_hit) begin
               state_d = c_st_hold;
            end
         end
         c_st_hold: begin
            if (!w_onehot) begin
               state_d = c_st_wait;
            end else if (w_changed) begin
               state_d = w_hit ? c_st_hold : c_st_qual;
            end
         end
         default: state_d = c_st_wait;
      endcase
   end

   // FSM output: capture once per stable run; HOLD only re-arms on a changed pair.
   always_comb begin
      w_capture = 1'b0;
      case (state_q)
         c_st_wait: w_capture = w_onehot && w_hit;
         c_st_qual: w_capture = w_onehot && w_hit;
         c_st_hold: w_capture = w_onehot && w_changed && w_hit;
         default:   w_capture = 1'b0;
      endcase
   end

   always_comb begin
      w_idx = 3'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (!an_q[i]) begin
            w_idx = 3'(i);
         end
      end
   end

   always_comb begin
      w_legal = 1'b1;
      w_nib   = 4'h0;
      case (seg_q)
         7'b1000000: w_nib = 4'h0;
         7'b1111001: w_nib = 4'h1;
         7'b0100100: w_nib = 4'h2;
         7'b0110000: w_nib = 4'h3;
         7'b0011001: w_nib = 4'h4;
         7'b0010010: w_nib = 4'h5;
         7'b0000010: w_nib = 4'h6;
         7'b1111000: w_nib = 4'h7;
         7'b0000000: w_nib = 4'h8;
         7'b0010000: w_nib = 4'h9;
         7'b0001000: w_nib = 4'hA;
         7'b0000011: w_nib = 4'hB;
         7'b1000110: w_nib = 4'hC;
         7'b0100001: w_nib = 4'hD;
         7'b0000110: w_nib = 4'hE;
         7'b0001110: w_nib = 4'hF;
         default:    w_legal = 1'b0;
      endcase
   end

   assign w_blank = (seg_q == c_blank);

   // A set on this cycle overrides a simultaneous clr_err.
   always_comb begin
      value_d   = value_q;
      valid_d   = valid_q;
      upd_d     = w_capture;
      upd_idx_d = upd_idx_q;
      err_d     = err_q;
      if (clr_err) begin
         err_d = 1'b0;
      end
      if (w_capture) begin
         upd_idx_d = w_idx;
         for (int i = 0; i < NDIG; i++) begin
            if (!an_q[i]) begin
               valid_d[i] = w_legal;
               if (w_legal) begin
                  value_d[4*i +: 4] = w_nib;
               end
            end
         end
         if (!w_legal && !w_blank) begin
            err_d = 1'b1;
         end
      end
   end

`ifdef SEG7DEC_DP_EN
   always_comb begin
      dp_d     = dp;
      dp_out_d = dp_out_q;
      for (int i = 0; i < NDIG; i++) begin
         if (w_capture && !an_q[i]) begin
            dp_out_d[i] = ~dp_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_q     <= 1'b1;
         dp_out_q <= '0;
      end else begin
         dp_q     <= dp_d;
         dp_out_q <= dp_out_d;
      end
   end

   assign dp_out = dp_out_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q     <= c_blank;
         an_q      <= '1;
         prev_q    <= '1;
         cnt_q     <= 8'd0;
         state_q   <= c_st_wait;
         value_q   <= '0;
         valid_q   <= '0;
         upd_q     <= 1'b0;
         upd_idx_q <= 3'd0;
         err_q     <= 1'b0;
      end else begin
         seg_q     <= seg_d;
         an_q      <= an_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         value_q   <= value_d;
         valid_q   <= valid_d;
         upd_q     <= upd_d;
         upd_idx_q <= upd_idx_d;
         err_q     <= err_d;
      end
   end

   assign value   = value_q;
   assign valid   = valid_q;
   assign upd     = upd_q;
   assign upd_idx = upd_idx_q;
   assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// =============================================================================
// tb_seg7_scan_decoder : directed plus random checks against a run-length model
// Rev 1.0
// =============================================================================
module tb_seg7_scan_decoder;

   localparam int NDIG = 4;
   localparam int S    = 4;
`ifdef SEG7DEC_DP_EN
   localparam bit DP_EN = 1'b1;
`else
   localparam bit DP_EN = 1'b0;
`endif

   typedef logic [11:0] pair_t;   // {dp, an[3:0], seg}

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = 7'h7F;
   logic [3:0]  an = 4'hF;
   logic        clr_err = 1'b0;
   logic [15:0] value;
   logic [3:0]  valid;
   logic        upd;
   logic [2:0]  upd_idx;
   logic        err;
`ifdef SEG7DEC_DP_EN
   logic        dp_r = 1'b1;
   logic [3:0]  dp_out;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   int n_upd  = 0;

   logic [6:0] codes [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   pair_t       hist[$];
   logic [15:0] m_value;
   logic [3:0]  m_valid;
   logic        m_upd;
   logic [2:0]  m_idx;
   logic        m_err;
   logic [3:0]  m_dp;

   seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
      .clk     (clk),
      .rst     (rst),
      .seg     (seg),
      .an      (an),
`ifdef SEG7DEC_DP_EN
      .dp      (dp_r),
      .dp_out  (dp_out),
`endif
      .clr_err (clr_err),
      .value   (value),
      .valid   (valid),
      .upd     (upd),
      .upd_idx (upd_idx),
      .err     (err)
   );

   always #5 clk = ~clk;

   function automatic int digit_of(input logic [3:0] a);
      if ($countones(~a) != 1) return -1;
      for (int i = 0; i < 4; i++) if (!a[i]) return i;
      return -1;
   endfunction

   function automatic int lookup(input logic [6:0] s);
      for (int n = 0; n < 16; n++) if (codes[n] == s) return n;
      return -1;
   endfunction

   // A capture is due when the newest S samples are identical, name one digit,
   // and the sample just before that run differed.
   function automatic bit cap_pending();
      int    n = hist.size();
      pair_t last;
      if (n < S + 1) return 1'b0;
      last = hist[n-1];
      if (digit_of(last[10:7]) < 0) return 1'b0;
      for (int k = 2; k <= S; k++) if (hist[n-k] != last) return 1'b0;
      return hist[n-1-S] != last;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("value", 32'(value), 32'(m_value));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("upd", 32'(upd), 32'(m_upd));
      chk("err", 32'(err), 32'(m_err));
      if (m_upd) chk("upd_idx", 32'(upd_idx), 32'(m_idx));
`ifdef SEG7DEC_DP_EN
      chk("dp_out", 32'(dp_out), 32'(m_dp));
`endif
   endtask

   task automatic model_reset();
      hist.delete();
      hist.push_back(12'hFFF);
      m_value = '0;
      m_valid = '0;
      m_upd   = 1'b0;
      m_idx   = '0;
      m_err   = 1'b0;
      m_dp    = '0;
   endtask

   // Drive one sample, predict outputs after the coming edge, compare at edge+1.
   task automatic step(input logic [6:0] s, input logic [3:0] a, input logic c, input logic d);
      int    dig;
      int    nib;
      logic  dd;
      pair_t last;
      dd = DP_EN ? d : 1'b1;
      seg = s;
      an = a;
      clr_err = c;
`ifdef SEG7DEC_DP_EN
      dp_r = dd;
`endif
      m_upd = 1'b0;
      if (c) m_err = 1'b0;
      if (cap_pending()) begin
         last  = hist[hist.size()-1];
         dig   = digit_of(last[10:7]);
         nib   = lookup(last[6:0]);
         m_upd = 1'b1;
         m_idx = 3'(dig);
         m_dp[dig] = ~last[11];
         if (nib >= 0) begin
            m_valid[dig] = 1'b1;
            m_value[4*dig +: 4] = nib[3:0];
         end else begin
            m_valid[dig] = 1'b0;
            if (last[6:0] != 7'h7F) m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_all();
      if (upd === 1'b1) n_upd++;
      hist.push_back({dd, a, s});
      if (hist.size() > S + 1) void'(hist.pop_front());
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst_upd_idx", 32'(upd_idx), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_upd_idx", 32'(upd_idx), 32'd0);
      rst = 1'b0;

      // Single digit '2' on digit 0: capture visible at edge 5.
      repeat (5) step(7'b0100100, 4'b1110, 1'b0, 1'b1);
      chk("tp1_upd", 32'(upd), 32'd1);
      chk("tp1_idx", 32'(upd_idx), 32'd0);
      chk("tp1_nib", 32'(value[3:0]), 32'h2);
      chk("tp1_valid", 32'(valid), 32'b0001);
      chk("tp1_err", 32'(err), 32'd0);
      step(7'b0100100, 4'b1110, 1'b0, 1'b1);
      chk("tp1_once", 32'(upd), 32'd0);

      // Four-digit scan with no blanking.
      n_upd = 0;
      repeat (8) step(7'b1111001, 4'b1110, 1'b0, 1'b1);
      repeat (8) step(7'b0110000, 4'b1101, 1'b0, 1'b1);
      repeat (8) step(7'b0011001, 4'b1011, 1'b0, 1'b1);
      repeat (8) step(7'b0001110, 4'b0111, 1'b0, 1'b1);
      chk("scan_value", 32'(value), 32'hF431);
      chk("scan_valid", 32'(valid), 32'hF);
      chk("scan_upds", 32'(n_upd), 32'd4);

      // Blank after a held '9' clears valid but keeps the nibble.
      repeat (9) step(7'b0010000, 4'b1101, 1'b0, 1'b1);
      repeat (5) step(7'b1111111, 4'b1101, 1'b0, 1'b1);
      chk("blank_valid1", 32'(valid[1]), 32'd0);
      chk("blank_nib1", 32'(value[7:4]), 32'h9);
      chk("blank_err", 32'(err), 32'd0);

      // Illegal pattern sets err; clear; then set wins over a same-cycle clear.
      repeat (5) step(7'b0101010, 4'b1110, 1'b0, 1'b1);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_valid0", 32'(valid[0]), 32'd0);
      step(7'b0101010, 4'b1110, 1'b1, 1'b1);
      chk("clr_err", 32'(err), 32'd0);
      repeat (4) step(7'b0101011, 4'b1011, 1'b0, 1'b1);
      step(7'b0101011, 4'b1011, 1'b1, 1'b1);
      chk("set_wins", 32'(err), 32'd1);
      chk("ill_valid2", 32'(valid[2]), 32'd0);

      // Short glitches and multi-anode patterns never capture.
      repeat (6) step(7'b0001000, 4'b0111, 1'b0, 1'b1);
      n_upd = 0;
      repeat (3) step(7'b0000000, 4'b0111, 1'b0, 1'b1);
      repeat (3) step(7'b0001000, 4'b0111, 1'b0, 1'b1);
      chk("glitch_no_upd", 32'(n_upd), 32'd0);
      n_upd = 0;
      repeat (10) step(7'b0010010, 4'b1100, 1'b0, 1'b1);
      chk("multi_an_no_upd", 32'(n_upd), 32'd0);

      // Reset with count at 3 of 4 returns everything to zero.
      repeat (4) step(7'b0010010, 4'b1011, 1'b0, 1'b1);
      do_reset();
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      repeat (5) step(7'b0010010, 4'b1011, 1'b0, 1'b1);

`ifdef SEG7DEC_DP_EN
      repeat (5) step(7'b1111000, 4'b1011, 1'b0, 1'b0);
      chk("dp_out2", 32'(dp_out[2]), 32'd1);
`endif

      // Random scan traffic: holds, blanks, garbage, odd anodes, stray clears.
      for (int t = 0; t < 120; t++) begin
         int         len;
         int         dig;
         int         kind;
         logic [6:0] s;
         logic [3:0] a;
         logic       d;
         kind = int'($urandom_range(0, 9));
         dig  = int'($urandom_range(0, 3));
         a    = 4'hF;
         a[dig] = 1'b0;
         if (kind == 0) a = 4'($urandom);
         s = codes[$urandom_range(0, 15)];
         if (kind == 1) s = 7'h7F;
         else if (kind == 2) s = 7'($urandom);
         d   = 1'($urandom);
         len = int'($urandom_range(1, 8));
         for (int k = 0; k < len; k++) step(s, a, ($urandom_range(0, 15) == 0), d);
         if (t == 70) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
